// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC core; registered Moore FSM, 2-5 cycles per instruction.
// Stalls in FETCH on imem_ready=0 and in MEM on dmem_ready=0; outputs are forced low while rst_n is asserted.
module multicycle_control_unit #(
  parameter int          OPCODE_W    = 4,
  parameter int          ALU_OP_W    = 2,
  parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                zero,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                beq,
  output logic                bne,
  output logic                jump,
  output logic [1:0]          pc_src,
  output logic                halted,
  output logic                illegal_op,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_LD, C_ST, C_R, C_BEQ, C_BNE, C_JMP, C_HALT, C_ILL
  } opc_class_t;

  state_t              r_state;
  state_t              w_next;
  logic [OPCODE_W-1:0] r_opc_q;
  logic                r_illegal_op;
  opc_class_t          w_class;
  logic [3:0]          w_opc_low;
  logic                w_upper_nz;

  logic [ALU_OP_W-1:0] w_alu_op;
  logic [1:0]          w_pc_src;
  logic w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write;
  logic w_alu_src, w_reg_dst, w_mem_to_reg, w_beq, w_bne, w_jump, w_halted;

  assign w_opc_low  = r_opc_q[3:0];
  assign w_upper_nz = |(r_opc_q >> 4);

  // Classification uses only the latched opcode, never the live input.
  always_comb begin
    w_class = C_ILL;
    if (w_upper_nz) begin
      w_class = C_ILL;
    end else if (w_opc_low == HALT_OPCODE) begin
      w_class = C_HALT;
    end else begin
      case (w_opc_low)
        4'd0:                                       w_class = C_LD;
        4'd1:                                       w_class = C_ST;
        4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: w_class = C_R;
        4'd11:                                      w_class = C_BEQ;
        4'd12:                                      w_class = C_BNE;
        4'd13:                                      w_class = C_JMP;
        default:                                    w_class = C_ILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opc_q      <= '0;
      r_illegal_op <= 1'b0;
    end else begin
      if (r_state == S_FETCH && imem_ready) begin
        r_opc_q <= opcode;
      end
      if (r_state == S_DECODE && w_class == C_ILL) begin
        r_illegal_op <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_alu_op     = '0;
    w_pc_src     = 2'd0;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_beq        = 1'b0;
    w_bne        = 1'b0;
    w_jump       = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (imem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_class)
          C_ILL:   w_next = S_FETCH;
          C_HALT:  w_next = S_HALT;
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        w_next = S_FETCH;
        case (w_class)
          C_LD, C_ST: begin
            w_alu_src = 1'b1;
            w_alu_op  = ALU_OP_W'(2'b10);
            w_next    = S_MEM;
          end
          C_R: begin
            w_reg_dst = 1'b1;
            w_next    = S_WB;
          end
          C_BEQ: begin
            w_beq      = 1'b1;
            w_alu_op   = ALU_OP_W'(2'b01);
            w_pc_write = zero;
            w_pc_src   = 2'd1;
          end
          C_BNE: begin
            w_bne      = 1'b1;
            w_alu_op   = ALU_OP_W'(2'b01);
            w_pc_write = !zero;
            w_pc_src   = 2'd1;
          end
          C_JMP: begin
            w_jump     = 1'b1;
            w_pc_write = 1'b1;
            w_pc_src   = 2'd2;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_alu_src   = 1'b1;
        w_alu_op    = ALU_OP_W'(2'b10);
        w_mem_read  = (w_class == C_LD);
        w_mem_write = (w_class == C_ST);
        if (dmem_ready) begin
          w_next = (w_class == C_LD) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (w_class == C_LD);
        w_reg_dst    = (w_class != C_LD);
        w_next       = S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
        w_next   = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Gating with rst_n makes the outputs drop asynchronously, even mid-cycle.
  assign alu_op     = rst_n ? w_alu_op : '0;
  assign pc_src     = rst_n ? w_pc_src : 2'd0;
  assign pc_write   = rst_n & w_pc_write;
  assign ir_write   = rst_n & w_ir_write;
  assign mem_read   = rst_n & w_mem_read;
  assign mem_write  = rst_n & w_mem_write;
  assign reg_write  = rst_n & w_reg_write;
  assign alu_src    = rst_n & w_alu_src;
  assign reg_dst    = rst_n & w_reg_dst;
  assign mem_to_reg = rst_n & w_mem_to_reg;
  assign beq        = rst_n & w_beq;
  assign bne        = rst_n & w_bne;
  assign jump       = rst_n & w_jump;
  assign halted     = rst_n & w_halted;
  assign illegal_op = r_illegal_op;
  assign state      = r_state;

  a_no_rw_mw: assert property (@(posedge clk) disable iff (!rst_n)
    !(reg_write && mem_write));
  a_one_write: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_FETCH) || $onehot0({reg_write, mem_write, pc_write}));

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle opcode decoder of the 16-bit RISC core. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and waits on instruction- and data-memory ready handshakes. It latches the opcode at fetch, flags illegal opcodes, supports a HALT opcode, and drives per-state datapath enables. It sits between the instruction register and the datapath.

Parameters:
OPCODE_W, 4, opcode width; must be at least 4; decode uses bits [3:0], and any nonzero bit above bit 3 is illegal
ALU_OP_W, 2, alu_op width; codes are zero-extended into this width
HALT_OPCODE, 4'b1111, low-4-bit opcode value that enters HALT

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  instruction opcode; sampled in FETCH when imem_ready=1
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete this cycle
zero  in  1  ALU zero flag, valid in EXECUTE
alu_op  out  ALU_OP_W  ALU operation class
pc_write, ir_write, mem_read, mem_write, reg_write  out  1 each  datapath enables
alu_src, reg_dst, mem_to_reg  out  1 each  datapath mux selects
beq, bne, jump  out  1 each  branch-type qualifiers
pc_src  out  2  next-PC select: 0 = pc+2, 1 = branch target, 2 = jump target
halted  out  1  core halted
illegal_op  out  1  sticky illegal-opcode flag
state  out  3  current state, for debug

Behaviour:
- Opcode classes (low 4 bits, upper bits zero): 0000 LD; 0001 ST; 0010–1001 ALU R-type; 1011 BEQ; 1100 BNE; 1101 JMP; HALT_OPCODE HALT.
- Any other opcode is illegal. Illegal means 1010, 1110, or any nonzero bit above bit 3.
- Registered Moore FSM. States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- All outputs are decoded from state and the opcode latched in opc_q. No output depends combinationally on opcode.
- Reset (asynchronous, rst_n=0): state=FETCH, opc_q=0, illegal_op=0. During reset, all enables and selects are 0 and halted=0.
- FETCH:
  - mem_read=1.
  - While imem_ready=0, hold FETCH with no other enables.
  - When imem_ready=1: ir_write=1, pc_write=1, pc_src=0, opc_q<=opcode; next state DECODE.
- DECODE: no enables. Next state by class:
  - illegal: set illegal_op=1, go to FETCH (instruction treated as a NOP).
  - HALT: go to HALT.
  - all others: go to EXEC.
- EXEC: per class.
  - LD/ST: alu_src=1, alu_op=2'b10; next MEM.
  - R-type: reg_dst=1, alu_src=0, alu_op=2'b00; next WB.
  - BEQ: beq=1, alu_op=2'b01; pc_write=zero, pc_src=1; next FETCH.
  - BNE: bne=1, alu_op=2'b01; pc_write=!zero, pc_src=1; next FETCH.
  - JMP: jump=1, pc_write=1, pc_src=2; next FETCH.
- MEM: alu_src=1 and alu_op=2'b10 held throughout.
  - LD: mem_read=1. ST: mem_write=1.
  - While dmem_ready=0, hold MEM with the same outputs.
  - When dmem_ready=1: LD goes to WB; ST goes to FETCH.
- WB: reg_write=1 for exactly one cycle; next FETCH.
  - LD: mem_to_reg=1, reg_dst=0.
  - R-type: mem_to_reg=0, reg_dst=1.
- HALT: halted=1, all enables 0. Absorbing; left only by reset.
- Latency in cycles, excluding wait cycles:
  - R-type: 4
  - LD: 5
  - ST: 4
  - BEQ/BNE/JMP: 3
  - illegal: 2
- At most one of reg_write, mem_write, pc_write may be asserted in a cycle other than FETCH.
- reg_write and mem_write must never both be 1.
- Reset asserted mid-instruction (e.g. MEM wait): outputs clear immediately (asynchronously); FSM restarts at FETCH on the first clock edge after deassertion.
- illegal_op is sticky until reset.
- Encodings 3'b110 and 3'b111 of the state register are unreachable and recover to FETCH.

Test Plan:
- Reset then R-type 0010, imem_ready=1, dmem_ready=1 → state sequence 0,1,2,4,0; reg_write=1 only in WB with reg_dst=1 and alu_op=00.
- LD 0000 with dmem_ready low for 3 cycles in MEM → mem_read held 3+1 cycles, then WB with mem_to_reg=1; total 8 cycles.
- BEQ 1011 with zero=1, then again with zero=0 → pc_write=1/pc_src=1 in EXEC for the first, pc_write=0 in EXEC for the second; each takes 3 cycles.
- Opcode 1010 (OPCODE_W=4), then with OPCODE_W=6 opcode 6'b010000 → illegal_op=1 in cycle after DECODE, no reg_write/mem_write, returns to FETCH and stays sticky.
- HALT 1111 → halted=1 from cycle 3 and indefinitely; further imem_ready pulses produce no ir_write; rst_n low → halted=0 immediately.
- ST 0001 stalled in MEM, rst_n pulsed low asynchronously mid-cycle → mem_write drops before the next edge; state=0 after release.
